// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply,
// restoring divide, one step per cycle, with a pipeline stall while busy.
module ex_muldiv_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [2:0]   op,
    input  logic [W-1:0] rs1,
    input  logic [W-1:0] rs2,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         stall
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q;
    logic [2:0]     op_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   rem_q;
    logic [W-1:0]   opb_q;
    logic           neg_q;
    logic           rneg_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   result_q;
    logic           done_q;
    logic           busy_q;

    function automatic logic [W-1:0] abs_fn(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? -x : x;
    endfunction

    // Upper half of the sign-corrected 2W product: -p = ~p + 1 carries into
    // the upper half only when the lower half is zero.
    function automatic logic [W-1:0] post_fn(
        input logic [2:0]     o,
        input logic [2*W-1:0] p,
        input logic [W-1:0]   q,
        input logic [W-1:0]   r,
        input logic           qn,
        input logic           rn
    );
        case (o)
            3'd0:              return p[W-1:0];
            3'd1, 3'd2, 3'd3:  return qn ? (~p[2*W-1:W] + W'(p[W-1:0] == '0)) : p[2*W-1:W];
            3'd4, 3'd5:        return qn ? -q : q;
            default:           return rn ? -r : r;
        endcase
    endfunction

    logic           a_sgn, b_sgn, a_neg, b_neg;
    logic [W-1:0]   a_abs, b_abs;
    logic           div0, ovf, special;
    logic [W-1:0]   special_val;

    always_comb begin
        a_sgn = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_sgn = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg = a_sgn && rs1[W-1];
        b_neg = b_sgn && rs2[W-1];
        a_abs = abs_fn(rs1, a_sgn);
        b_abs = abs_fn(rs2, b_sgn);
        div0  = op[2] && (rs2 == '0);
        ovf   = ((op == 3'd4) || (op == 3'd6)) && (rs1 == {1'b1, {(W-1){1'b0}}}) && (rs2 == '1);
        special = div0 || ovf;
        if (div0)
            special_val = op[1] ? rs1 : '1;
        else
            special_val = op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_acc;
    logic [W:0]     trial;
    logic           ge;
    logic [W-1:0]   div_rem;
    logic [W-1:0]   div_quo;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_acc = {mul_sum, acc_q[W-1:1]};
        // Trial remainder needs W+1 bits: shifted value can reach 2*divisor-1.
        trial   = {rem_q, acc_q[W-1]};
        ge      = trial >= {1'b0, opb_q};
        div_rem = ge ? W'(trial - {1'b0, opb_q}) : trial[W-1:0];
        div_quo = {acc_q[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q   <= op;
                        cnt_q  <= '0;
                        neg_q  <= a_neg ^ b_neg;
                        rneg_q <= a_neg;
                        if (special) begin
                            result_q <= special_val;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            acc_q   <= op[2] ? {{W{1'b0}}, a_abs} : {{W{1'b0}}, b_abs};
                            opb_q   <= op[2] ? b_abs : a_abs;
                            rem_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= op_q[2] ? {acc_q[2*W-1:W], div_quo} : mul_acc;
                    rem_q <= op_q[2] ? div_rem : rem_q;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        result_q <= post_fn(op_q, mul_acc, div_quo, div_rem, neg_q, rneg_q);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign stall  = (start && (state_q == IDLE) && !flush) || (state_q == CALC);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: per-feature tasks with inline checks.
module tb_ex_muldiv_unit;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;
    logic        done, busy, stall;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .rs1(rs1), .rs2(rs2), .result(result), .done(done), .busy(busy), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Presents one instruction (caller is just after a rising edge) and observes
    // it until done or the cycle limit; returns just after the edge ending DONE.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int limit, output int done_cyc, output logic [31:0] res,
                         output int stall_cnt, output int stall_end);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        done_cyc = -1; res = '0; stall_cnt = 0; stall_end = -1;
        for (int c = 0; c <= limit; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            else if (stall_end < 0) stall_end = c;
            if (done) begin done_cyc = c; res = result; end
            @(posedge clk); #1;
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_init();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL init_result got %h want %h", result, 32'h0); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL init_done got %b want 0", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL init_busy got %b want 0", busy); end
        checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL init_stall got %b want 0", stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int dc, sc, se; logic [31:0] r;
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 40, dc, r, sc, se);
        checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h want %h", r, 32'hFFFFFFEB); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL mul_done_cycle got %0d want 33", dc); end
        checks++; if (sc !== 33) begin errors++; $display("FAIL mul_stall_count got %0d want 33", sc); end
        checks++; if (se !== 33) begin errors++; $display("FAIL mul_stall_end got %0d want 33", se); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b want 0", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [4] = '{3'd3, 3'd1, 3'd2, 3'd1};
        logic [31:0] as  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] bs  [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd3};
        logic [31:0] ex  [4] = '{32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int dc, sc, se; logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 40, dc, r, sc, se);
            checks++; if (r !== ex[i]) begin errors++; $display("FAIL mulh_result[%0d] got %h want %h", i, r, ex[i]); end
            checks++; if (dc !== 33) begin errors++; $display("FAIL mulh_done_cycle[%0d] got %0d want 33", i, dc); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        logic [31:0] ex  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        int dc, sc, se; logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 40, dc, r, sc, se);
            checks++; if (r !== ex[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, r, ex[i]); end
            checks++; if (dc !== 33) begin errors++; $display("FAIL div_done_cycle[%0d] got %0d want 33", i, dc); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [5] = '{3'd5, 3'd6, 3'd4, 3'd4, 3'd6};
        logic [31:0] as  [5] = '{32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [5] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        int dc, sc, se; logic [31:0] r;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], 5, dc, r, sc, se);
            checks++; if (r !== ex[i]) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, r, ex[i]); end
            checks++; if (dc !== 1) begin errors++; $display("FAIL special_done_cycle[%0d] got %0d want 1", i, dc); end
            checks++; if (sc !== 1) begin errors++; $display("FAIL special_stall_count[%0d] got %0d want 1", i, sc); end
        end
    endtask

    task automatic test_flush();
        int dones; int dc, sc, se; logic [31:0] r;
        start = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd6;
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        dones = 0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); if (done) dones++; end
        checks++; if (dones !== 0) begin errors++; $display("FAIL flush_no_done got %0d pulses want 0", dones); end
        // Flush together with start in IDLE: the instruction must not be taken.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b want 0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL flush_idle_accept got %0d active cycles want 0", dones); end
        @(posedge clk); #1;
        issue(3'd0, 32'd5, 32'd6, 40, dc, r, sc, se);
        checks++; if (r !== 32'd30) begin errors++; $display("FAIL flush_recover got %h want %h", r, 32'd30); end
    endtask

    task automatic test_back_to_back();
        int dc, sc, se; logic [31:0] r;
        issue(3'd0, 32'h12345678, 32'h10, 40, dc, r, sc, se);
        checks++; if (r !== 32'h23456780) begin errors++; $display("FAIL b2b_first got %h want %h", r, 32'h23456780); end
        issue(3'd3, 32'h80000000, 32'd4, 40, dc, r, sc, se);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL b2b_second got %h want %h", r, 32'd2); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_done_cycle got %0d want 33", dc); end
        checks++; if (se !== 33) begin errors++; $display("FAIL b2b_stall_end got %0d want 33", se); end
    endtask

    task automatic test_reset();
        start = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b want 1", busy); end
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want %h", result, 32'h0); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset_init();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, covering RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Consumes the operand and opcode fields that the ID/EX pipeline register presents.
- While an operation is in flight, it asserts a stall that holds the ID/EX register (deasserts EN) and the upstream stages.
- Delivers the result on a one-cycle done pulse, then releases the pipeline.

Parameters:
- W, 32, operand/result width in bits. Iteration count equals W.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  ID/EX holds a valid mul/div instruction.
- flush  input  1  squash current instruction (branch or exception); synchronous.
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1  input  W  operand A (multiplicand/dividend).
- rs2  input  W  operand B (multiplier/divisor).
- result  output  W  registered result; valid only while done=1.
- done  output  1  one-cycle pulse; result valid.
- busy  output  1  high in CALC.
- stall  output  1  freeze ID/EX and upstream: (start & state==IDLE & ~flush) | state==CALC.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE, result=0, done=0, busy=0.
  - Internal accumulator, quotient and count cleared.
  - rst has priority over flush and start.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 & flush=0: latch op, rs1, rs2.
  - Signed ops take absolute values and record the result sign:
    - MULH: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - DIV/REM: both signed.
    - MUL low word is sign-independent.
  - Set count=0. Go to CALC, or to DONE if a special divide case applies (below).
- CALC:
  - Multiply: one shift-add step per cycle on a 2W product.
  - Divide: one restoring shift-subtract step per cycle.
  - count increments each cycle; after count==W-1, go to DONE.
- DONE:
  - done=1; result = post-processed, sign-corrected value; stall=0 so ID/EX advances this edge.
  - Next state is always IDLE. done is never high for 2 consecutive cycles.
- Latency:
  - Normal op: start seen in IDLE at cycle 0, done at cycle W+1; stall high for cycles 0..W (W+1 cycles).
  - Special divide case: done at cycle 1; stall high for cycle 0 only.
- Result selection:
  - MUL: product[W-1:0].
  - MULH/MULHSU/MULHU: product[2W-1:W], after two's-complement correction of the full 2W product when the sign flag is set.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special divide cases (no iteration):
  - Divisor 0: quotient = all ones; remainder = rs1 unmodified, for both signed and unsigned.
  - Signed overflow, rs1 = -2^(W-1) and rs2 = -1: quotient = -2^(W-1), remainder = 0.
- flush:
  - In any state, abort: next state IDLE, done=0, no result delivered.
  - flush in IDLE together with start: the op is not accepted.
- start in CALC or DONE is ignored; operands are not relatched.
- start still high in IDLE the cycle after DONE is treated as a new instruction. The ID/EX register advanced on the DONE edge, so this start belongs to the next instruction.
- result holds its last value outside DONE; consumers must qualify it with done.
- All arithmetic is modulo 2^W on outputs, with no X propagation. Internal product is 2W bits; internal remainder is W+1 bits.

Test Plan:
- Reset: assert rst for 2 cycles during CALC -> next cycle state IDLE, result=0, done=0, stall=0 (with start=0).
- MUL: rs1=7, rs2=0xFFFFFFFD (-3), op=0 -> done at cycle 33, result=0xFFFFFFEB; stall high exactly cycles 0..32.
- MULHU: rs1=rs2=0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV/REM: rs1=0xFFFFFFF9 (-7), rs2=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Special cases, each with done at cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Flush mid-op: start MUL, flush at cycle 10 -> cycle 11 state IDLE, stall=0, no done pulse for it.
- Back-to-back: new start presented the cycle after DONE -> accepted, second done at +33 with the correct result.
